// File: rtl/cpu_pkg.sv
// Shared types for the core's hazard and forwarding logic.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    // EX operand source select, registered alongside the instruction entering EX
    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    // Load-use sequencer state
    typedef enum logic {
        HZ_RUN   = 1'b0,
        HZ_STALL = 1'b1
    } hz_state_e;

    // XZR reads as zero and discards writes, so it never carries a dependency
    localparam logic [4:0] XZR = 5'd31;

endpackage

// File: rtl/hz_shadow_stage.sv
// Shadow copy of one pipeline register's rd / reg_wr / mem_rd fields.
// Latency: 1 cycle from inputs to outputs.
// Backpressure: none; loads every cycle, kill loads an all-zero (bubble) entry.
module hz_shadow_stage #(
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             kill,
    input  logic [REG_W-1:0] rd_in,
    input  logic             reg_wr_in,
    input  logic             mem_rd_in,
    output logic [REG_W-1:0] rd,
    output logic             reg_wr,
    output logic             mem_rd
);

    logic [REG_W-1:0] rd_d,     rd_q;
    logic             reg_wr_d, reg_wr_q;
    logic             mem_rd_d, mem_rd_q;

    // Next entry: the incoming fields, or a bubble when killed
    always_comb begin
        rd_d     = kill ? '0   : rd_in;
        reg_wr_d = kill ? 1'b0 : reg_wr_in;
        mem_rd_d = kill ? 1'b0 : mem_rd_in;
    end

    // Slice register, cleared to a bubble on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q     <= '0;
            reg_wr_q <= 1'b0;
            mem_rd_q <= 1'b0;
        end else begin
            rd_q     <= rd_d;
            reg_wr_q <= reg_wr_d;
            mem_rd_q <= mem_rd_d;
        end
    end

    assign rd     = rd_q;
    assign reg_wr = reg_wr_q;
    assign mem_rd = mem_rd_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use stall, bubble injection, branch flush and forwarding select for the 5-stage core.
// Latency: hazard to stall/bubble 0 cycles; forwarding select registered, 1 cycle ahead of use.
// Backpressure: load-use stalls hold PC and IF/ID for LOAD_USE_STALLS cycles; stall beats flush.
module pipeline_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int REG_W           = 5,
    parameter int ZERO_REG        = XZR,
    parameter int LOAD_USE_STALLS = 1,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_wr,
    input  logic             id_mem_rd,
    input  logic             id_br_taken,
    output logic             pc_wr_en,
    output logic             ifid_wr_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [REG_W-1:0] ZR = ZERO_REG[REG_W-1:0];
    // The hazard cycle itself is the first bubble; the STALL state supplies the rest.
    localparam bit         HAS_EXTRA = (LOAD_USE_STALLS > 1);
    localparam logic [1:0] CNT_INIT  = HAS_EXTRA ? 2'(LOAD_USE_STALLS - 2) : 2'd0;

    // Shadows of ID/EX and EX/MEM destination fields
    logic [REG_W-1:0] ex_rd,  mem_rd;
    logic             ex_reg_wr, ex_mem_rd, mem_reg_wr;
    logic             mem_mem_rd_unused;

    hz_shadow_stage #(.REG_W(REG_W)) u_ex_shadow (
        .clk       (clk),
        .reset     (reset),
        .kill      (idex_bubble || !id_valid),
        .rd_in     (id_rd),
        .reg_wr_in (id_reg_wr),
        .mem_rd_in (id_mem_rd),
        .rd        (ex_rd),
        .reg_wr    (ex_reg_wr),
        .mem_rd    (ex_mem_rd)
    );

    hz_shadow_stage #(.REG_W(REG_W)) u_mem_shadow (
        .clk       (clk),
        .reset     (reset),
        .kill      (1'b0),
        .rd_in     (ex_rd),
        .reg_wr_in (ex_reg_wr),
        .mem_rd_in (ex_mem_rd),
        .rd        (mem_rd),
        .reg_wr    (mem_reg_wr),
        .mem_rd    (mem_mem_rd_unused)
    );

    hz_state_e        state_d,     state_q;
    logic [1:0]       cnt_d,       cnt_q;
    fwd_sel_e         fwd_a_d,     fwd_a_q;
    fwd_sel_e         fwd_b_d,     fwd_b_q;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

    logic hit_ex_a, hit_ex_b, hit_mem_a, hit_mem_b;
    logic hazard, stall;

    // A real dependency on a producer: used operand, same index, producer writes, not XZR
    function automatic logic dep_match(input logic             use_r,
                                       input logic [REG_W-1:0] r,
                                       input logic [REG_W-1:0] s_rd,
                                       input logic             s_wr);
        return use_r && (r == s_rd) && s_wr && (r != ZR);
    endfunction

    // Dependency compares and the load-use stall decision
    always_comb begin
        hit_ex_a  = dep_match(id_use_rn, id_rn, ex_rd,  ex_reg_wr);
        hit_ex_b  = dep_match(id_use_rm, id_rm, ex_rd,  ex_reg_wr);
        hit_mem_a = dep_match(id_use_rn, id_rn, mem_rd, mem_reg_wr);
        hit_mem_b = dep_match(id_use_rm, id_rm, mem_rd, mem_reg_wr);
        hazard    = (state_q == HZ_RUN) && id_valid && ex_mem_rd && (hit_ex_a || hit_ex_b);
        stall     = hazard || (state_q == HZ_STALL);
    end

    // Stall sequencing; a load already past EX cannot raise a new hazard while stalled
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            HZ_RUN: begin
                if (hazard && HAS_EXTRA) begin
                    state_d = HZ_STALL;
                    cnt_d   = CNT_INIT;
                end
            end
            HZ_STALL: begin
                if (cnt_q == 2'd0) begin
                    state_d = HZ_RUN;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: state_d = HZ_RUN;
        endcase
    end

    // Forwarding selects for the instruction entering EX; younger EX producer wins over MEM
    always_comb begin
        fwd_a_d = FWD_REG;
        fwd_b_d = FWD_REG;
        if (!stall) begin
            if (hit_ex_a && !ex_mem_rd) begin
                fwd_a_d = FWD_EXMEM;
            end else if (hit_mem_a) begin
                fwd_a_d = FWD_MEMWB;
            end
            if (hit_ex_b && !ex_mem_rd) begin
                fwd_b_d = FWD_EXMEM;
            end else if (hit_mem_b) begin
                fwd_b_d = FWD_MEMWB;
            end
        end
    end

    // Bubble-cycle counter, saturating at all-ones
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Sequencer state, registered selects and counter; reset drops any stall in progress
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= HZ_RUN;
            cnt_q       <= 2'd0;
            fwd_a_q     <= FWD_REG;
            fwd_b_q     <= FWD_REG;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pc_wr_en    = !stall;
    assign ifid_wr_en  = !stall;
    assign idex_bubble = stall;
    assign ifid_flush  = id_br_taken && id_valid && !stall;
    assign fwd_a       = fwd_a_q;
    assign fwd_b       = fwd_b_q;
    assign stall_cnt   = stall_cnt_q;

endmodule
